arm7tdmi_mul_seq: RTL and testbench

ARM7TDMI_MUL_SEQ -- requirements
Module: arm7tdmi_mul_seq

---
 rtl/arm7tdmi_mul_seq.sv | 205 ++++++++++++++++++++
 tb/tb_arm7tdmi_mul_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_mul_seq.sv
// arm7tdmi_mul_seq: sequencer for the ARM7TDMI MUL/MLA/UMULL/UMLAL/SMULL/SMLAL
// family. Latches the instruction and operands, drives the external multiply
// unit, holds the pipeline for the internal cycle count, then writes back one
// (short) or two (long) registers and optionally updates N/Z.
// Optional feature: define MUL_EARLY_TERM_EN to enable early termination based
// on the magnitude of Rs; undefined, the multiplier always takes m=4.
module arm7tdmi_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] rm_data,
  input  logic [31:0] rs_data,
  input  logic [31:0] rn_data,
  input  logic [31:0] rdhi_data,
  output logic        mul_en,
  output logic        mul_long,
  output logic        mul_signed,
  output logic        mul_accumulate,
  output logic        mul_set_flags,
  output logic [1:0]  mul_type,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [31:0] acc_hi,
  output logic [31:0] acc_lo,
  input  logic [31:0] result_hi,
  input  logic [31:0] result_lo,
  input  logic        result_ready,
  input  logic        negative,
  input  logic        zero,
  output logic        busy,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        flags_we,
  output logic        flag_n,
  output logic        flag_z,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] WB_LO = 2'd2;
  localparam logic [1:0] WB_HI = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  ctrl_q, ctrl_d;        // {long, signed, accumulate, S}
  logic [3:0]  rd_q, rd_d;            // Rd / RdHi
  logic [3:0]  rn_idx_q, rn_idx_d;    // Rn / RdLo
  logic [31:0] rm_q, rm_d, rs_q, rs_d, rn_q, rn_d, rdhi_q, rdhi_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        neg_q, neg_d, zero_q, zero_d, got_q, got_d;

  logic [2:0]  m;
  logic [3:0]  icount;
  logic [3:0]  cyc;
  logic        signed_long;
  logic        last_wr;
  logic        unused_instr;

  // Condition code, opcode bits and Rs/Rm register numbers are not needed here.
  assign unused_instr = ^{instr[31:24], instr[11:0]};

  // Internal cycle count I = m + accumulate + long, m from the magnitude of Rs.
  always_comb begin
    signed_long = ctrl_q[3] & ctrl_q[2];
    m = 3'd4;
`ifdef MUL_EARLY_TERM_EN
    if ((rs_q[31:8] == 24'd0) || (signed_long && (&rs_q[31:8])))
      m = 3'd1;
    else if ((rs_q[31:16] == 16'd0) || (signed_long && (&rs_q[31:16])))
      m = 3'd2;
    else if ((rs_q[31:24] == 8'd0) || (signed_long && (&rs_q[31:24])))
      m = 3'd3;
`endif
    icount = {1'b0, m} + {3'd0, ctrl_q[1]} + {3'd0, ctrl_q[3]};
    cyc    = {1'b0, cnt_q} + 4'd1;
  end

  // Next-state logic: accept, execute with flush/result wait, write back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    rd_d     = rd_q;
    rn_idx_d = rn_idx_q;
    rm_d     = rm_q;
    rs_d     = rs_q;
    rn_d     = rn_q;
    rdhi_d   = rdhi_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    got_d    = got_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ctrl_d   = instr[23:20];
          rd_d     = instr[19:16];
          rn_idx_d = instr[15:12];
          rm_d     = rm_data;
          rs_d     = rs_data;
          rn_d     = rn_data;
          rdhi_d   = rdhi_data;
          cnt_d    = 3'd0;
          got_d    = 1'b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (!got_q && result_ready) begin
          res_hi_d = result_hi;
          res_lo_d = result_lo;
          neg_d    = negative;
          zero_d   = zero;
          got_d    = 1'b1;
        end
        if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
        if (flush)
          state_d = IDLE;
        else if ((cyc >= icount) && (got_q || result_ready))
          state_d = WB_LO;
      end
      WB_LO: state_d = ctrl_q[3] ? WB_HI : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      ctrl_q   <= 4'd0;
      rd_q     <= 4'd0;
      rn_idx_q <= 4'd0;
      rm_q     <= 32'd0;
      rs_q     <= 32'd0;
      rn_q     <= 32'd0;
      rdhi_q   <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      got_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      rd_q     <= rd_d;
      rn_idx_q <= rn_idx_d;
      rm_q     <= rm_d;
      rs_q     <= rs_d;
      rn_q     <= rn_d;
      rdhi_q   <= rdhi_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      got_q    <= got_d;
    end
  end

  // Output decode: multiply-unit controls, write port, flags and done pulse.
  always_comb begin
    busy           = (state_q != IDLE);
    mul_en         = (state_q == EXEC) && (cnt_q == 3'd0);
    mul_long       = ctrl_q[3];
    mul_signed     = ctrl_q[2];
    mul_accumulate = ctrl_q[1];
    mul_set_flags  = ctrl_q[0];
    mul_type       = {ctrl_q[3], ctrl_q[1]};
    operand_a      = rm_q;
    operand_b      = rs_q;
    acc_lo         = rn_q;
    acc_hi         = rdhi_q;
    wr_en          = 1'b0;
    wr_addr        = 4'd0;
    wr_data        = 32'd0;
    last_wr        = 1'b0;
    case (state_q)
      WB_LO: begin
        wr_en   = 1'b1;
        wr_addr = ctrl_q[3] ? rn_idx_q : rd_q;
        wr_data = res_lo_q;
        last_wr = ~ctrl_q[3];
      end
      WB_HI: begin
        wr_en   = 1'b1;
        wr_addr = rd_q;
        wr_data = res_hi_q;
        last_wr = 1'b1;
      end
      default: ;
    endcase
    done     = last_wr;
    flags_we = last_wr & ctrl_q[0];
    flag_n   = last_wr & ctrl_q[0] & neg_q;
    flag_z   = last_wr & ctrl_q[0] & zero_q;
  end

endmodule

// File: tb/tb_arm7tdmi_mul_seq.sv
// tb_arm7tdmi_mul_seq: table-driven and randomized checks of the multiply
// sequencer, plus hand-written flush and reset sequences.
module tb_arm7tdmi_mul_seq;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr = '0, rm_data = '0, rs_data = '0, rn_data = '0, rdhi_data = '0;
  logic [31:0] result_hi = '0, result_lo = '0;
  logic        result_ready = 1'b0, negative = 1'b0, zero = 1'b0;
  logic        mul_en, mul_long, mul_signed, mul_accumulate, mul_set_flags;
  logic [1:0]  mul_type;
  logic [31:0] operand_a, operand_b, acc_hi, acc_lo;
  logic        busy, wr_en, flags_we, flag_n, flag_z, done;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  int total = 0;
  int bad = 0;

  arm7tdmi_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .instr(instr),
    .rm_data(rm_data), .rs_data(rs_data), .rn_data(rn_data), .rdhi_data(rdhi_data),
    .mul_en(mul_en), .mul_long(mul_long), .mul_signed(mul_signed),
    .mul_accumulate(mul_accumulate), .mul_set_flags(mul_set_flags), .mul_type(mul_type),
    .operand_a(operand_a), .operand_b(operand_b), .acc_hi(acc_hi), .acc_lo(acc_lo),
    .result_hi(result_hi), .result_lo(result_lo), .result_ready(result_ready),
    .negative(negative), .zero(zero), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flags_we(flags_we), .flag_n(flag_n), .flag_z(flag_z), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          lng, sgn, acc, s;
    logic [3:0]  rd, rn;
    logic [31:0] rm, rs, rnv, rdhi;
    int          lat;
    int          exp_exec;
    logic [31:0] exp_lo, exp_hi;
    bit          exp_n, exp_z;
  } vec_t;

  vec_t tbl[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit lng, sgn, acc, s, input logic [3:0] rd, rn,
                              input logic [31:0] rm, rs, rnv, rdhi, input int lat,
                              input int ex, input logic [31:0] lo, hi, input bit n, z);
    vec_t v;
    v.lng = lng; v.sgn = sgn; v.acc = acc; v.s = s; v.rd = rd; v.rn = rn;
    v.rm = rm; v.rs = rs; v.rnv = rnv; v.rdhi = rdhi; v.lat = lat;
    v.exp_exec = ex; v.exp_lo = lo; v.exp_hi = hi; v.exp_n = n; v.exp_z = z;
    return v;
  endfunction

  // Reference model: architectural result via 64-bit arithmetic, cycle count
  // from the signed/unsigned magnitude range of Rs.
  function automatic vec_t fillExpect(input vec_t v);
    vec_t r;
    longint unsigned p;
    longint sp;
    longint sv;
    int m;
    int ic;
    r = v;
    if (!v.lng) begin
      p = 64'(v.rm) * 64'(v.rs) + (v.acc ? 64'(v.rnv) : 64'd0);
      r.exp_lo = p[31:0]; r.exp_hi = v.rdhi;
      r.exp_n = p[31]; r.exp_z = (p[31:0] == 32'd0);
    end else begin
      if (v.sgn) begin
        sp = longint'($signed(v.rm)) * longint'($signed(v.rs)) +
             (v.acc ? longint'({v.rdhi, v.rnv}) : 64'sd0);
        p = longint'(sp);
      end else
        p = 64'(v.rm) * 64'(v.rs) + (v.acc ? {v.rdhi, v.rnv} : 64'd0);
      r.exp_lo = p[31:0]; r.exp_hi = p[63:32];
      r.exp_n = p[63]; r.exp_z = (p == 64'd0);
    end
    m = 4;
    if (ET) begin
      if (v.lng && v.sgn) begin
        sv = longint'($signed(v.rs));
        if (sv >= -256 && sv < 256) m = 1;
        else if (sv >= -65536 && sv < 65536) m = 2;
        else if (sv >= -16777216 && sv < 16777216) m = 3;
      end else begin
        if (v.rs < 32'd256) m = 1;
        else if (v.rs < 32'd65536) m = 2;
        else if (v.rs < 32'd16777216) m = 3;
      end
    end
    ic = m + int'(v.acc) + int'(v.lng);
    r.exp_exec = (v.lat > ic) ? v.lat : ic;
    return r;
  endfunction

  // Issue one multiply, play the multiply unit, and check EXEC length and writes.
  task automatic applyStimulus(input vec_t v, input bit hold_start, input bit flush_wb);
    int exec;
    bit mulen_bad;
    @(negedge clk);
    instr = {4'hE, 4'h0, v.lng, v.sgn, v.acc, v.s, v.rd, v.rn, 4'h3, 4'h9, 4'h2};
    rm_data = v.rm; rs_data = v.rs; rn_data = v.rnv; rdhi_data = v.rdhi;
    start = 1'b1; result_ready = 1'b0;
    result_hi = v.exp_hi; result_lo = v.exp_lo; negative = v.exp_n; zero = v.exp_z;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    instr = ~instr; rm_data = ~rm_data; rs_data = ~rs_data; rn_data = ~rn_data; rdhi_data = ~rdhi_data;
    checkOutput("operand_a", operand_a, v.rm);
    checkOutput("operand_b", operand_b, v.rs);
    checkOutput("acc_lo", acc_lo, v.rnv);
    checkOutput("acc_hi", acc_hi, v.rdhi);
    checkOutput("mul_type", {30'd0, mul_type}, {30'd0, v.lng, v.acc});
    checkOutput("mul_ctrl", {28'd0, mul_long, mul_signed, mul_accumulate, mul_set_flags},
                {28'd0, v.lng, v.sgn, v.acc, v.s});
    exec = 0;
    mulen_bad = 1'b0;
    while (busy && !wr_en && exec < 40) begin
      exec++;
      if (mul_en !== (exec == 1)) mulen_bad = 1'b1;
      if (exec > v.lat) begin
        result_lo = ~v.exp_lo; result_hi = ~v.exp_hi; negative = ~v.exp_n; zero = ~v.exp_z;
      end
      result_ready = (exec >= v.lat);
      @(negedge clk);
    end
    result_ready = 1'b0;
    start = 1'b0;
    checkOutput("exec_cycles", exec, v.exp_exec);
    checkOutput("mul_en_first_only", {31'd0, mulen_bad}, 32'd0);
    flush = flush_wb;
    checkOutput("wb_lo_en", {31'd0, wr_en}, 32'd1);
    checkOutput("wb_lo_addr", {28'd0, wr_addr}, {28'd0, (v.lng ? v.rn : v.rd)});
    checkOutput("wb_lo_data", wr_data, v.exp_lo);
    if (v.lng) begin
      checkOutput("wb_lo_not_final", {30'd0, done, flags_we}, 32'd0);
      @(negedge clk);
      checkOutput("wb_hi_en", {31'd0, wr_en}, 32'd1);
      checkOutput("wb_hi_addr", {28'd0, wr_addr}, {28'd0, v.rd});
      checkOutput("wb_hi_data", wr_data, v.exp_hi);
    end
    flush = 1'b0;
    checkOutput("done", {31'd0, done}, 32'd1);
    checkOutput("flags_we", {31'd0, flags_we}, {31'd0, v.s});
    if (v.s) checkOutput("flags_nz", {30'd0, flag_n, flag_z}, {30'd0, v.exp_n, v.exp_z});
    @(negedge clk);
    checkOutput("idle_after", {29'd0, busy, wr_en, done}, 32'd0);
  endtask

  // Flush in the second EXEC cycle of a UMULL must abandon it silently.
  task automatic flushSeq();
    int seen;
    @(negedge clk);
    instr = 32'hE080_0392 | (32'h5 << 16) | (32'h4 << 12);
    rm_data = 32'hFFFF_FFFF; rs_data = 32'hFFFF_FFFF; start = 1'b1;
    result_lo = 32'h1; result_hi = 32'hFFFF_FFFE;
    @(negedge clk);
    start = 1'b0; result_ready = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_idle", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (8) begin
      if (wr_en || done) seen++;
      @(negedge clk);
    end
    result_ready = 1'b0;
    checkOutput("flush_no_write", seen, 0);
  endtask

  // Reset mid-EXEC forces every output low at once and cancels the write.
  task automatic resetSeq();
    int seen;
    @(negedge clk);
    instr = 32'hE080_0392 | (32'h5 << 16) | (32'h4 << 12);
    rm_data = 32'h1234_5678; rs_data = 32'hFFFF_FFFF; rn_data = 32'h11; rdhi_data = 32'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; result_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ctrl", {26'd0, busy, wr_en, done, mul_en, flags_we, mul_long}, 32'd0);
    checkOutput("rst_operand_a", operand_a, 32'd0);
    checkOutput("rst_wr", wr_data | {28'd0, wr_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      if (wr_en || done || busy) seen++;
      @(negedge clk);
    end
    result_ready = 1'b0;
    checkOutput("rst_no_write", seen, 0);
  endtask

  initial begin
    vec_t v;
    int sh;
    tbl[0] = mk(0, 0, 0, 1, 4'd1, 4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1,
                ET ? 1 : 4, 32'd35, 32'd0, 0, 0);
    tbl[1] = mk(0, 0, 1, 0, 4'd2, 4'd3, 32'd3, 32'h0001_0000, 32'd2, 32'd0, 1,
                ET ? 4 : 5, 32'h0003_0002, 32'd0, 0, 0);
    tbl[2] = mk(1, 0, 0, 0, 4'd5, 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1,
                5, 32'h0000_0001, 32'hFFFF_FFFE, 1, 0);
    tbl[3] = mk(1, 1, 0, 1, 4'd7, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1,
                ET ? 2 : 5, 32'h0000_0001, 32'h0, 0, 0);
    tbl[4] = mk(0, 0, 0, 1, 4'd3, 4'd0, 32'd0, 32'h0000_1234, 32'd0, 32'd0, 1,
                ET ? 2 : 4, 32'd0, 32'd0, 0, 1);
    tbl[5] = mk(1, 1, 1, 1, 4'd9, 4'd10, 32'd2, 32'hFFFF_FF00, 32'd0, 32'd0, 1,
                ET ? 3 : 6, 32'hFFFF_FE00, 32'hFFFF_FFFF, 1, 0);
    tbl[6] = mk(0, 0, 0, 0, 4'd11, 4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 3,
                ET ? 3 : 4, 32'd35, 32'd0, 0, 0);
    tbl[7] = mk(1, 0, 1, 0, 4'd8, 4'd8, 32'h10, 32'h10, 32'd1, 32'd2, 1,
                ET ? 3 : 6, 32'h101, 32'h2, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {26'd0, busy, wr_en, done, mul_en, flags_we, flag_n}, 32'd0);
    checkOutput("reset_bus", operand_a | operand_b | acc_hi | acc_lo | wr_data, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      applyStimulus(tbl[i], i == 1, i == 7);

    for (int i = 0; i < 12; i++) begin
      v.lng = 1'($urandom); v.sgn = 1'($urandom); v.acc = 1'($urandom); v.s = 1'($urandom);
      v.rd = 4'($urandom); v.rn = 4'($urandom);
      v.rm = $urandom; v.rnv = $urandom; v.rdhi = $urandom;
      sh = $urandom_range(0, 31);
      v.rs = $urandom >> sh;
      if (v.sgn && $urandom_range(0, 1) == 1) v.rs = ~v.rs;
      v.lat = $urandom_range(1, 7);
      v = fillExpect(v);
      applyStimulus(v, 1'b0, 1'b0);
    end

    flushSeq();
    resetSeq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
